// File: rtl/multicycle_ctrl.sv
// Control sequencer for the multi-cycle RV32I core.
// A single memory port is shared between instruction fetch and load/store.
// The FSM walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK. It issues per-state enables to the datapath, counts retired
// instructions, and parks in HALT on an illegal instruction.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   instr, eq, mem_ready  instruction register, ALU equal flag, memory done
//   mem_req .. immsrc     datapath / memory control strobes and selects
//   state, halt, retired  debug state, sticky halt, retired-instruction count
module multicycle_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             eq,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pcsrc,
    output logic             regwrite,
    output logic             resultsrc,
    output logic             alusrc,
    output logic [2:0]       aluctrl,
    output logic [2:0]       immsrc,
    output logic [2:0]       state,
    output logic             halt,
    output logic [WIDTH-1:0] retired
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             halt_q, halt_d;
    logic [WIDTH-1:0] retired_q, retired_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_r, is_addi, is_lw, is_sw, is_br;
    logic       r_ok, br_ok, taken, retire;
    logic [2:0] r_aluctrl;
    logic       dec_alusrc;
    logic [2:0] dec_aluctrl, dec_immsrc;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign rd           = instr[11:7];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^instr[24:15];

    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_br   = (opcode == OP_BR);

    // Only beq (000) and bne (001) are supported.
    assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign taken = (funct3 == 3'b000) ? eq : !eq;

    // R-type whitelist: add, sub, and, or, slt.
    always_comb begin
        r_ok      = 1'b0;
        r_aluctrl = ALU_ADD;
        case (funct3)
            3'b000: begin
                if (funct7 == 7'b0000000) begin
                    r_ok = 1'b1;
                end else if (funct7 == 7'b0100000) begin
                    r_ok      = 1'b1;
                    r_aluctrl = ALU_SUB;
                end
            end
            3'b111: begin r_ok = (funct7 == 7'b0000000); r_aluctrl = ALU_AND; end
            3'b110: begin r_ok = (funct7 == 7'b0000000); r_aluctrl = ALU_OR;  end
            3'b010: begin r_ok = (funct7 == 7'b0000000); r_aluctrl = ALU_SLT; end
            default: ;
        endcase
    end

    // ALU/immediate selects per instruction class. They are held from EXECUTE
    // through WRITEBACK so the ALU result stays stable across those states.
    always_comb begin
        dec_alusrc  = 1'b0;
        dec_aluctrl = ALU_ADD;
        dec_immsrc  = IMM_I;
        if (is_r) begin
            dec_aluctrl = r_aluctrl;
        end else if (is_addi || is_lw) begin
            dec_alusrc = 1'b1;
        end else if (is_sw) begin
            dec_alusrc = 1'b1;
            dec_immsrc = IMM_S;
        end else if (is_br) begin
            dec_aluctrl = ALU_SUB;
            dec_immsrc  = IMM_B;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        retired_d = retired_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsrc     = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 1'b0;
        alusrc    = 1'b0;
        aluctrl   = ALU_ADD;
        immsrc    = IMM_I;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if ((is_r && r_ok) || is_addi || is_lw || is_sw || is_br) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_EXECUTE: begin
                alusrc  = dec_alusrc;
                aluctrl = dec_aluctrl;
                immsrc  = dec_immsrc;
                if (is_r || is_addi) begin
                    state_d = S_WRITEBACK;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEMORY;
                end else if (is_br && br_ok) begin
                    pc_we   = 1'b1;
                    pcsrc   = taken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEMORY: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                alusrc   = dec_alusrc;
                aluctrl  = dec_aluctrl;
                immsrc   = dec_immsrc;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                alusrc    = dec_alusrc;
                aluctrl   = dec_aluctrl;
                immsrc    = dec_immsrc;
                regwrite  = (rd != 5'd0);
                resultsrc = is_lw;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (state_d == S_HALT) begin
            halt_d = 1'b1;
        end
        if (retire) begin
            retired_d = retired_q + WIDTH'(1);
        end

        // Strobes are suppressed while reset is asserted.
        if (!rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            regwrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            halt_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign halt    = halt_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [31:0]      instr;
    logic             eq;
    logic             mem_ready;
    logic             mem_req, mem_we, addr_sel, ir_we, pc_we, pcsrc;
    logic             regwrite, resultsrc, alusrc;
    logic [2:0]       aluctrl, immsrc, state;
    logic             halt;
    logic [WIDTH-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    // Strobe vector: mem_req mem_we addr_sel ir_we pc_we pcsrc regwrite resultsrc
    logic [7:0] strobes;
    assign strobes = {mem_req, mem_we, addr_sel, ir_we, pc_we, pcsrc, regwrite, resultsrc};

    multicycle_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pcsrc(pcsrc), .regwrite(regwrite), .resultsrc(resultsrc),
        .alusrc(alusrc), .aluctrl(aluctrl), .immsrc(immsrc), .state(state),
        .halt(halt), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check state and strobes for the current cycle, then step past the next edge.
    task automatic exp_cycle(input string tag, input logic [2:0] st, input logic [7:0] stb);
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_strobe"}, 32'(strobes), 32'(stb));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        exp_cycle({tag, "_fetch"}, 3'd0, 8'h90);
        exp_cycle({tag, "_decode"}, 3'd1, 8'h00);
    endtask

    task automatic check_alu(input string tag, input logic s, input logic [2:0] c, input logic [2:0] i);
        #1;
        check({tag, "_alusrc"}, 32'(alusrc), 32'(s));
        check({tag, "_aluctrl"}, 32'(aluctrl), 32'(c));
        check({tag, "_immsrc"}, 32'(immsrc), 32'(i));
    endtask

    // R-type/addi: FETCH, DECODE, EXECUTE, WRITEBACK.
    task automatic run_alu_op(input string tag, input logic [31:0] ins, input logic s,
                              input logic [2:0] c, input logic [7:0] wb_stb,
                              input logic [31:0] exp_ret);
        fetch_decode(tag, ins);
        check_alu({tag, "_ex"}, s, c, 3'b000);
        exp_cycle({tag, "_ex"}, 3'd2, 8'h00);
        exp_cycle({tag, "_wb"}, 3'd4, wb_stb);
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    task automatic run_branch(input string tag, input logic [31:0] ins, input logic e,
                              input logic [7:0] ex_stb, input logic [31:0] exp_ret);
        eq = e;
        fetch_decode(tag, ins);
        check_alu({tag, "_ex"}, 1'b0, 3'b001, 3'b010);
        exp_cycle({tag, "_ex"}, 3'd2, ex_stb);
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_state_after"}, 32'(state), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        instr     = 32'h0;
        eq        = 1'b0;
        mem_ready = 1'b1;

        // Reset hold for two edges with mem_ready high.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobe", 32'(strobes), 32'h0);
        check("rst_retired", retired, 32'd0);
        check("rst_halt", 32'(halt), 32'd0);

        // First FETCH: request alone while memory stalls, then with ir_we.
        rst       = 1'b1;
        mem_ready = 1'b0;
        exp_cycle("fetch_wait", 3'd0, 8'h80);

        // addi x1,x0,5
        run_alu_op("addi", 32'h00500093, 1'b1, 3'b000, 8'h0A, 32'd1);

        // lw x2,0(x1) with three wait cycles in MEMORY
        fetch_decode("lw", 32'h0000A103);
        check_alu("lw_ex", 1'b1, 3'b000, 3'b000);
        exp_cycle("lw_ex", 3'd2, 8'h00);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) exp_cycle("lw_memwait", 3'd3, 8'hA0);
        mem_ready = 1'b1;
        exp_cycle("lw_memdone", 3'd3, 8'hA0);
        exp_cycle("lw_wb", 3'd4, 8'h0B);
        check("lw_retired", retired, 32'd2);

        // sw x2,0(x1) with one wait cycle
        fetch_decode("sw", 32'h0020A023);
        check_alu("sw_ex", 1'b1, 3'b000, 3'b001);
        exp_cycle("sw_ex", 3'd2, 8'h00);
        mem_ready = 1'b0;
        check_alu("sw_mem", 1'b1, 3'b000, 3'b001);
        exp_cycle("sw_memwait", 3'd3, 8'hE0);
        mem_ready = 1'b1;
        exp_cycle("sw_memdone", 3'd3, 8'hE8);
        check("sw_retired", retired, 32'd3);

        // Branches
        run_branch("bne_taken", 32'h00209463, 1'b0, 8'h0C, 32'd4);
        run_branch("bne_nottaken", 32'h00209463, 1'b1, 8'h08, 32'd5);
        run_branch("beq_taken", 32'h00208463, 1'b1, 8'h0C, 32'd6);
        run_branch("beq_nottaken", 32'h00208463, 1'b0, 8'h08, 32'd7);

        // R-type: sub, and, or, slt, and add targeting x0 (no regwrite)
        run_alu_op("sub", 32'h402081B3, 1'b0, 3'b001, 8'h0A, 32'd8);
        run_alu_op("and", 32'h0020F1B3, 1'b0, 3'b010, 8'h0A, 32'd9);
        run_alu_op("or", 32'h0020E1B3, 1'b0, 3'b011, 8'h0A, 32'd10);
        run_alu_op("slt", 32'h0020A1B3, 1'b0, 3'b101, 8'h0A, 32'd11);
        run_alu_op("add_x0", 32'h00208033, 1'b0, 3'b000, 8'h08, 32'd12);

        // Illegal opcode: HALT is sticky and ignores mem_ready
        fetch_decode("illegal", 32'h0000007F);
        for (int k = 0; k < 10; k++) begin
            check("illegal_halt", 32'(halt), 32'd1);
            exp_cycle("illegal_hold", 3'd5, 8'h00);
        end
        check("illegal_retired", retired, 32'd12);

        // One reset cycle clears halt and the counter
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("unhalt_halt", 32'(halt), 32'd0);
        check("unhalt_retired", retired, 32'd0);
        exp_cycle("unhalt_fetch", 3'd0, 8'h90);
        exp_cycle("unhalt_decode", 3'd1, 8'h00);
        instr = 32'h0;
        exp_cycle("unhalt_nop_ex", 3'd5, 8'h00);

        // Unsupported R funct (xor) halts from DECODE
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_decode("xor", 32'h0020C1B3);
        check("xor_state", 32'(state), 32'd5);
        check("xor_halt", 32'(halt), 32'd1);

        // Unsupported branch funct3 halts from EXECUTE without retiring
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_decode("br010", 32'h0020A463);
        exp_cycle("br010_ex", 3'd2, 8'h00);
        check("br010_state", 32'(state), 32'd5);
        check("br010_retired", retired, 32'd0);

        // Reset in the middle of a stalled load access
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_decode("lwrst", 32'h0000A103);
        exp_cycle("lwrst_ex", 3'd2, 8'h00);
        mem_ready = 1'b0;
        exp_cycle("lwrst_memwait", 3'd3, 8'hA0);
        rst = 1'b0;
        #1;
        check("lwrst_strobe_in_rst", 32'(strobes), 32'h20);
        @(posedge clk);
        #1;
        check("lwrst_state", 32'(state), 32'd0);
        check("lwrst_retired", retired, 32'd0);
        check("lwrst_strobe", 32'(strobes), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
